dm_arbiter: RTL and testbench
=============================

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter LOCK_MAX, default 8: maximum consecutive locked grants to one port before forced release.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (reset==0 at a rising clk edge resets).
REQ-004 req  input  2  per-port access request; bit0 = port0 (pipeline MEM stage), bit1 = port1 (debug/loader).
REQ-005 we  input  2  per-port write enable; 0 = read.
REQ-006 lock  input  2  per-port burst lock request.
REQ-007 addr  input  64  {addr1, addr0}; byte addresses, 32 bits each.
REQ-008 wdata  input  64  {wdata1, wdata0}; store data, byte lanes aligned to the word.
REQ-009 be  input  8  {be1, be0}; per-port 4-bit byte enables, bit i = byte lane i.
REQ-010 gnt  output  2  per-port grant, one-hot or zero, combinational in the current cycle.
REQ-011 rvalid  output  2  per-port read-data-valid, registered.
REQ-012 rdata  output  32  registered read data, shared, qualified by rvalid.
REQ-013 Address  output  32  word-aligned address to the data memory.
REQ-014 Data  output  32  merged write word to the data memory.
REQ-015 MemWrite  output  1  data-memory word write strobe.
REQ-016 MemData  input  32  combinational read word from the data memory.

Function
REQ-017 The arbiter SHALL grant at most one port per cycle; a transfer completes in the cycle where req[x] and gnt[x] are both 1.
REQ-018 FSM states SHALL be IDLE, OWN0, OWN1; a round-robin pointer rr (1 bit) SHALL record the preferred port in IDLE.
REQ-019 In IDLE, a single requester SHALL be granted; with both requesting, port rr SHALL be granted.
REQ-020 After any non-locked grant to port x, rr SHALL become !x at the next edge.
REQ-021 In IDLE, a grant to port x with lock[x]=1 SHALL move to OWNx, load the beat counter with 1, and keep rr unchanged.
REQ-022 In OWNx, only port x SHALL be granted (gnt[x]=req[x]); the other port's requests SHALL be ignored.
REQ-023 In OWNx, each granted beat SHALL increment the beat counter; the FSM SHALL return to IDLE with rr=!x when req[x]=0, lock[x]=0, or the counter reaches LOCK_MAX after a granted beat.
REQ-024 Address SHALL equal {granted addr[31:2], 2'b00}; with no grant, Address, Data and MemWrite SHALL be 0.
REQ-025 MemWrite SHALL be 1 iff the granted port has we=1 and be!=0; a granted write with be=0 completes with no memory write.
REQ-026 Data byte lane i SHALL be wdata lane i when be[i]=1, else MemData lane i (read-modify-write in one cycle).
REQ-027 A granted read SHALL assert rvalid[x]=1 and load rdata with MemData in the following cycle; latency is exactly 1 cycle.
REQ-028 rvalid SHALL be 0 in any cycle not following a granted read; rdata SHALL hold its last value otherwise.
REQ-029 Back-to-back reads from alternating ports SHALL each produce their rvalid one cycle after their grant with no bubble.

Reset
REQ-030 On reset: state=IDLE, rr=0, beat counter=0, rvalid=0, rdata=0.
REQ-031 During the reset cycle gnt, Address, Data and MemWrite SHALL be 0 regardless of inputs.
REQ-032 Reset asserted in OWNx SHALL abandon the lock; the first post-reset arbitration SHALL follow IDLE rules with rr=0.

Structure
REQ-033 A shared package dm_arb_pkg SHALL hold the state encoding (IDLE, OWN0, OWN1), NPORT=2 and the LOCK_MAX default.
REQ-034 Byte-lane merging SHALL live in one sub-module, dm_byte_merge (inputs wdata, be, MemData; output merged word).

Verification
REQ-035 Both req=2'b11, lock=0, reads, 4 cycles from reset -> gnt sequence 01,10,01,10; rvalid follows each grant by 1 cycle.
REQ-036 Port0 write addr=0x13, be=4'b0010, wdata=0x0000AB00, MemData=0x11223344 -> Address=0x10, Data=0x1122AB44, MemWrite=1.
REQ-037 Port1 lock=1, req held 12 cycles, port0 also requesting, LOCK_MAX=8 -> port1 granted 8 beats, then port0 granted next cycle.
REQ-038 Port0 write with be=0 -> gnt[0]=1, MemWrite=0; memory contents unchanged.
REQ-039 reset=0 applied in OWN1 at beat 3 with both requesting -> gnt=0 during reset; first grant after release goes to port0.
REQ-040 Port0 read addr=0x20, MemData=0xDEADBEEF -> next cycle rvalid=2'b01, rdata=0xDEADBEEF; following idle cycle rvalid=0, rdata held.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : dm_arb_pkg                                                   |
// | Description : Shared constants for the data-memory arbiter.                |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

package dm_arb_pkg;

    localparam int c_NPORT        = 2;
    localparam int c_LOCK_MAX_DEF = 8;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_OWN0 = 2'd1;
    localparam logic [1:0] c_OWN1 = 2'd2;

endpackage

`default_nettype wire

// File: rtl/dm_byte_merge.sv
// +----------------------------------------------------------------------------+
// | Module      : dm_byte_merge                                                |
// | Description : Per-byte-lane merge of store data over the current word.     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module dm_byte_merge (
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    input  logic [31:0] MemData,
    output logic [31:0] merged
);

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign merged[8*i +: 8] = be[i] ? wdata[8*i +: 8] : MemData[8*i +: 8];
    end

endmodule

`default_nettype wire

// File: rtl/dm_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module      : dm_arbiter                                                   |
// | Description : Two-port data-memory arbiter with round-robin and burst lock.|
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int LOCK_MAX = c_LOCK_MAX_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [c_NPORT-1:0]    req,
    input  logic [c_NPORT-1:0]    we,
    input  logic [c_NPORT-1:0]    lock,
    input  logic [63:0]           addr,
    input  logic [63:0]           wdata,
    input  logic [7:0]            be,
    output logic [c_NPORT-1:0]    gnt,
    output logic [c_NPORT-1:0]    rvalid,
    output logic [31:0]           rdata,
    output logic [31:0]           Address,
    output logic [31:0]           Data,
    output logic                  MemWrite,
    input  logic [31:0]           MemData
);

    localparam int c_BW = $clog2(LOCK_MAX + 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_rr;
    logic               w_rr_nxt;
    logic [c_BW-1:0]    r_beat;
    logic [c_BW-1:0]    w_beat_nxt;
    logic [c_BW-1:0]    w_beat_inc;
    logic [c_NPORT-1:0] r_rvalid;
    logic [31:0]        r_rdata;

    logic [c_NPORT-1:0] w_gnt;
    logic               w_sel;
    logic               w_any;
    logic               w_we;
    logic               w_rd;
    logic [31:0]        w_addr;
    logic [31:0]        w_wdata;
    logic [3:0]         w_be;
    logic [31:0]        w_merged;
    logic               w_unused;

    // Grant is forced low while reset is held so nothing reaches memory.
    always_comb begin
        w_gnt = '0;
        if (reset) begin
            case (r_state)
                c_IDLE: begin
                    case (req)
                        2'b01:   w_gnt = 2'b01;
                        2'b10:   w_gnt = 2'b10;
                        2'b11:   w_gnt = r_rr ? 2'b10 : 2'b01;
                        default: w_gnt = 2'b00;
                    endcase
                end
                c_OWN0:  w_gnt = {1'b0, req[0]};
                c_OWN1:  w_gnt = {req[1], 1'b0};
                default: w_gnt = '0;
            endcase
        end
    end

    assign w_sel    = w_gnt[1];
    assign w_any    = |w_gnt;
    assign w_addr   = w_sel ? addr[63:32]  : addr[31:0];
    assign w_wdata  = w_sel ? wdata[63:32] : wdata[31:0];
    assign w_be     = w_sel ? be[7:4]      : be[3:0];
    assign w_we     = we[w_sel];
    assign w_rd     = w_any & ~w_we;
    assign w_unused = &{1'b0, w_addr[1:0]};

    dm_byte_merge u_merge (
        .wdata   (w_wdata),
        .be      (w_be),
        .MemData (MemData),
        .merged  (w_merged)
    );

    assign gnt      = w_gnt;
    assign Address  = w_any ? {w_addr[31:2], 2'b00} : 32'h0;
    assign Data     = w_any ? w_merged : 32'h0;
    assign MemWrite = w_any & w_we & (|w_be);
    assign rvalid   = r_rvalid;
    assign rdata    = r_rdata;

    assign w_beat_inc = r_beat + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr;
        w_beat_nxt  = r_beat;
        case (r_state)
            c_IDLE: begin
                if (w_any) begin
                    if (lock[w_sel]) begin
                        w_state_nxt = w_sel ? c_OWN1 : c_OWN0;
                        w_beat_nxt  = c_BW'(1);
                    end else begin
                        w_rr_nxt = ~w_sel;
                    end
                end
            end
            c_OWN0, c_OWN1: begin
                // The owner releases on dropped request/lock or when the burst cap is hit.
                if (!req[r_state[1]] || !lock[r_state[1]] || (w_beat_inc >= c_BW'(LOCK_MAX))) begin
                    w_state_nxt = c_IDLE;
                    w_rr_nxt    = ~r_state[1];
                    w_beat_nxt  = '0;
                end else begin
                    w_beat_nxt = w_beat_inc;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_beat_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= c_IDLE;
            r_rr     <= 1'b0;
            r_beat   <= '0;
            r_rvalid <= '0;
            r_rdata  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr     <= w_rr_nxt;
            r_beat   <= w_beat_nxt;
            r_rvalid <= w_rd ? w_gnt : '0;
            if (w_rd) begin
                r_rdata <= MemData;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dm_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_dm_arbiter                                                |
// | Description : Scoreboard bench for dm_arbiter with a word-memory model.    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_dm_arbiter;

    localparam int c_LM = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req, we, lock;
    logic [63:0] addr, wdata;
    logic [7:0]  be;
    logic [1:0]  gnt, rvalid;
    logic [31:0] rdata, Address, Data, MemData;
    logic        MemWrite;

    bit [31:0]   mem     [64];
    bit [31:0]   ref_mem [64];
    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [31:0] pl_val;

    int          m_state;
    bit          m_rr;
    int          m_beat;
    logic [31:0] m_rdata;
    logic [33:0] sbq [$];

    int          n_checks = 0;
    int          n_errors = 0;
    logic [1:0]  obs_gnt;
    logic [31:0] obs_addr, obs_data;
    logic        obs_mw;

    always #5 clk = ~clk;

    dm_arbiter #(.LOCK_MAX(c_LM)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .we       (we),
        .lock     (lock),
        .addr     (addr),
        .wdata    (wdata),
        .be       (be),
        .gnt      (gnt),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .Address  (Address),
        .Data     (Data),
        .MemWrite (MemWrite),
        .MemData  (MemData)
    );

    assign MemData = mem[Address[7:2]];

    always @(posedge clk) begin
        if (pl_en)         mem[pl_idx]        <= pl_val;
        else if (MemWrite) mem[Address[7:2]]  <= Data;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic set_idle();
        req = 2'b00; we = 2'b00; lock = 2'b00;
        addr = 64'h0; wdata = 64'h0; be = 8'h0;
    endtask

    // One clock: check combinational outputs, advance the model, then check registered outputs.
    task automatic run_cycle();
        logic [1:0]  eg;
        logic        gi, any, w, x;
        logic [31:0] ad, wd, md, mg, ea;
        logic [3:0]  b;
        logic [33:0] e;
        #1;
        eg = 2'b00;
        if (reset) begin
            case (m_state)
                0:       eg = (req == 2'b11) ? (m_rr ? 2'b10 : 2'b01) : req;
                1:       eg = {1'b0, req[0]};
                default: eg = {req[1], 1'b0};
            endcase
        end
        gi  = eg[1];
        any = |eg;
        ad  = gi ? addr[63:32]  : addr[31:0];
        wd  = gi ? wdata[63:32] : wdata[31:0];
        b   = gi ? be[7:4]      : be[3:0];
        w   = we[gi];
        ea  = any ? {ad[31:2], 2'b00} : 32'h0;
        md  = ref_mem[ea[7:2]];
        for (int i = 0; i < 4; i++) mg[8*i +: 8] = b[i] ? wd[8*i +: 8] : md[8*i +: 8];
        chk("gnt", gnt, eg);
        chk("Address", Address, ea);
        chk("Data", Data, any ? mg : 32'h0);
        chk("MemWrite", MemWrite, any && w && (b != 4'h0));
        obs_gnt = gnt; obs_addr = Address; obs_data = Data; obs_mw = MemWrite;
        if (!reset) begin
            m_state = 0; m_rr = 1'b0; m_beat = 0; m_rdata = 32'h0;
            sbq.push_back({2'b00, 32'h0});
        end else begin
            if (any && w && (b != 4'h0)) ref_mem[ea[7:2]] = mg;
            if (any && !w) begin
                m_rdata = md;
                sbq.push_back({eg, md});
            end else begin
                sbq.push_back({2'b00, m_rdata});
            end
            if (m_state == 0) begin
                if (any) begin
                    if (lock[gi]) begin m_state = gi ? 2 : 1; m_beat = 1; end
                    else m_rr = ~gi;
                end
            end else begin
                x = (m_state == 2);
                if (!req[x] || !lock[x]) begin
                    m_state = 0; m_rr = ~x; m_beat = 0;
                end else begin
                    m_beat++;
                    if (m_beat >= c_LM) begin m_state = 0; m_rr = ~x; m_beat = 0; end
                end
            end
        end
        if (pl_en) ref_mem[pl_idx] = pl_val;
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("rvalid", rvalid, e[33:32]);
        chk("rdata", rdata, e[31:0]);
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        set_idle();
        pl_en = 1'b1; pl_idx = 6'(idx); pl_val = val;
        run_cycle();
        pl_en = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n1;
        bit  seen0;
        m_state = 0; m_rr = 1'b0; m_beat = 0; m_rdata = 32'h0;
        pl_en = 1'b0; pl_idx = 6'd0; pl_val = 32'h0;

        // Reset held with every input active.
        reset = 1'b0; set_idle(); req = 2'b11; lock = 2'b11; we = 2'b11; be = 8'hFF;
        repeat (2) run_cycle();
        chk("rst_gnt", obs_gnt, 2'b00);
        chk("rst_mw", obs_mw, 1'b0);

        // Alternating reads from both ports.
        reset = 1'b1; set_idle(); req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            run_cycle();
            chk($sformatf("rr_seq%0d", i), obs_gnt, (i % 2) ? 2'b10 : 2'b01);
            chk($sformatf("rr_rvalid%0d", i), rvalid, (i % 2) ? 2'b10 : 2'b01);
        end

        // Partial-byte store merged over memory contents.
        preload(4, 32'h11223344);
        set_idle(); req = 2'b01; we = 2'b01; addr[31:0] = 32'h13; be[3:0] = 4'b0010;
        wdata[31:0] = 32'h0000AB00;
        run_cycle();
        chk("wr_addr", obs_addr, 32'h10);
        chk("wr_data", obs_data, 32'h1122AB44);
        chk("wr_mw", obs_mw, 1'b1);
        chk("wr_mem", mem[4], 32'h1122AB44);

        // Write with no byte enables leaves memory untouched.
        preload(16, 32'h55667788);
        set_idle(); req = 2'b01; we = 2'b01; addr[31:0] = 32'h40; wdata[31:0] = 32'hFFFFFFFF;
        run_cycle();
        chk("be0_gnt", obs_gnt, 2'b01);
        chk("be0_mw", obs_mw, 1'b0);
        set_idle(); run_cycle();
        chk("be0_mem", mem[16], 32'h55667788);

        // Single read, then an idle cycle that must hold rdata.
        preload(8, 32'hDEADBEEF);
        set_idle(); req = 2'b01; addr[31:0] = 32'h20;
        run_cycle();
        chk("rd_rvalid", rvalid, 2'b01);
        chk("rd_rdata", rdata, 32'hDEADBEEF);
        set_idle(); run_cycle();
        chk("rd_idle_rvalid", rvalid, 2'b00);
        chk("rd_idle_rdata", rdata, 32'hDEADBEEF);

        // Port1 locked burst capped at c_LM beats while port0 waits.
        set_idle(); req = 2'b10; lock = 2'b10;
        n1 = 0; seen0 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) req = 2'b11;
            run_cycle();
            if (!seen0) begin
                if (obs_gnt == 2'b10) n1++;
                else if (obs_gnt == 2'b01) seen0 = 1'b1;
            end
        end
        chk("lock_beats", 64'(n1), 64'(c_LM));
        chk("lock_release", 64'(seen0), 64'd1);

        // Reset in the middle of a locked burst.
        set_idle(); repeat (2) run_cycle();
        req = 2'b10; lock = 2'b10; run_cycle();
        req = 2'b11; repeat (2) run_cycle();
        reset = 1'b0; run_cycle();
        chk("lockrst_gnt", obs_gnt, 2'b00);
        reset = 1'b1; run_cycle();
        chk("lockrst_first", obs_gnt, 2'b01);

        // Random traffic against the model.
        repeat (400) begin
            reset = ($urandom_range(0, 15) != 0);
            req   = 2'($urandom);
            we    = 2'($urandom);
            lock  = 2'($urandom);
            addr  = {24'h0, 8'($urandom), 24'h0, 8'($urandom)};
            wdata = {$urandom, $urandom};
            be    = 8'($urandom);
            run_cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
